// File: rtl/control_unit_if.sv
// Instruction/flag inputs and control-word/state outputs of control_unit.
// slave = the control unit itself, master = the datapath side that drives it.
interface control_unit_if;
    logic [31:0] i_instruction;
    logic        i_zero;
    logic [31:0] o_ctrl;
    logic [2:0]  o_state;

    modport master (output i_instruction, output i_zero, input o_ctrl, input o_state);
    modport slave  (input i_instruction, input i_zero, output o_ctrl, output o_state);
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control unit: 5-phase FSM producing the 32-bit datapath control word.
// Optional macro ILLEGAL_OPCODE_HALT_EN: unrecognised opcodes halt in state 6 instead of running as a NOP.
module control_unit (
    input  logic          i_clk,
    input  logic          i_rst,
    control_unit_if.slave bus
);
    typedef enum logic [2:0] {
        FETCH      = 3'd1,
        DECODE     = 3'd2,
        EXECUTE    = 3'd3,
        MEMORY     = 3'd4,
        WRITE_BACK = 3'd5,
        HALT       = 3'd6
    } state_t;

    typedef enum logic [1:0] {DEST_NONE, DEST_RD, DEST_RT, DEST_R31} dest_t;
    typedef enum logic [1:0] {PC_NEXT, PC_BEQ, PC_BNE, PC_JUMP} pc_kind_t;

    localparam int PC_LOAD      = 0;
    localparam int PC_SEL_1     = 1;
    localparam int PC_SEL_2     = 2;
    localparam int PC_SEL_3     = 3;
    localparam int IR_LOAD      = 4;
    localparam int MEM_R        = 5;
    localparam int MEM_W        = 6;
    localparam int REG_R        = 8;
    localparam int REG_W        = 9;
    localparam int WA_SEL_1     = 10;
    localparam int WA_SEL_3     = 12;
    localparam int OP2_SEL_4    = 21;
    localparam int ALU_OPRN_LSB = 22;
    localparam int MA_SEL_2     = 27;
    localparam int MD_SEL_1     = 28;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_MULI  = 6'h1D;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_MUL = 6'h2C;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SLL = 6'h01;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_MUL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_AND = 4'd6;
    localparam logic [3:0] ALU_OR  = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd8;
    localparam logic [3:0] ALU_SLT = 4'd9;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] w_ctrl;
    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic [3:0]  w_alu_oprn;
    logic        w_is_rtype;
    logic        w_mem_rd;
    logic        w_mem_wr;
    dest_t       w_dest;
    pc_kind_t    w_pc_kind;
    logic        w_unused_fields;

    assign w_opcode        = bus.i_instruction[31:26];
    assign w_funct         = bus.i_instruction[5:0];
    assign w_unused_fields = ^bus.i_instruction[25:6];

    // An R-type word with an unknown funct is treated like an unknown opcode.
    always_comb begin
        w_alu_oprn = 4'd0;
        w_is_rtype = 1'b0;
        w_mem_rd   = 1'b0;
        w_mem_wr   = 1'b0;
        w_dest     = DEST_NONE;
        w_pc_kind  = PC_NEXT;
        case (w_opcode)
            OP_RTYPE: begin
                w_is_rtype = 1'b1;
                w_dest     = DEST_RD;
                case (w_funct)
                    FN_ADD:  w_alu_oprn = ALU_ADD;
                    FN_SUB:  w_alu_oprn = ALU_SUB;
                    FN_MUL:  w_alu_oprn = ALU_MUL;
                    FN_SRL:  w_alu_oprn = ALU_SRL;
                    FN_SLL:  w_alu_oprn = ALU_SLL;
                    FN_AND:  w_alu_oprn = ALU_AND;
                    FN_OR:   w_alu_oprn = ALU_OR;
                    FN_NOR:  w_alu_oprn = ALU_NOR;
                    FN_SLT:  w_alu_oprn = ALU_SLT;
                    default: begin
                        w_is_rtype = 1'b0;
                        w_dest     = DEST_NONE;
                    end
                endcase
            end
            OP_ADDI: begin w_alu_oprn = ALU_ADD; w_dest = DEST_RT; end
            OP_MULI: begin w_alu_oprn = ALU_MUL; w_dest = DEST_RT; end
            OP_ANDI: begin w_alu_oprn = ALU_AND; w_dest = DEST_RT; end
            OP_ORI:  begin w_alu_oprn = ALU_OR;  w_dest = DEST_RT; end
            OP_SLTI: begin w_alu_oprn = ALU_SLT; w_dest = DEST_RT; end
            OP_LW:   begin w_alu_oprn = ALU_ADD; w_dest = DEST_RT; w_mem_rd = 1'b1; end
            OP_SW:   begin w_alu_oprn = ALU_ADD; w_mem_wr = 1'b1; end
            OP_BEQ:  begin w_alu_oprn = ALU_SUB; w_pc_kind = PC_BEQ; end
            OP_BNE:  begin w_alu_oprn = ALU_SUB; w_pc_kind = PC_BNE; end
            OP_JMP:  w_pc_kind = PC_JUMP;
            OP_JAL:  begin w_pc_kind = PC_JUMP; w_dest = DEST_R31; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= FETCH;
        else       r_state <= w_next_state;
    end

    // PC select: PC+1 = pc_sel_1, branch target = pc_sel_2, jump target = pc_sel_2|pc_sel_3.
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = 32'h0000_0000;
        case (r_state)
            FETCH: begin
                w_next_state     = DECODE;
                w_ctrl[MEM_R]    = 1'b1;
                w_ctrl[MA_SEL_2] = 1'b1;
            end
            DECODE: begin
`ifdef ILLEGAL_OPCODE_HALT_EN
                // Every recognised instruction has a nonzero ALU op except the jumps.
                w_next_state = (w_alu_oprn != 4'd0 || w_pc_kind == PC_JUMP) ? EXECUTE : HALT;
`else
                w_next_state = EXECUTE;
`endif
                w_ctrl[MEM_R]    = 1'b1;
                w_ctrl[MA_SEL_2] = 1'b1;
                w_ctrl[IR_LOAD]  = 1'b1;
                w_ctrl[REG_R]    = 1'b1;
            end
            EXECUTE: begin
                w_next_state                  = MEMORY;
                w_ctrl[REG_R]                 = 1'b1;
                w_ctrl[ALU_OPRN_LSB +: 4]     = w_alu_oprn;
                w_ctrl[OP2_SEL_4]             = w_is_rtype;
            end
            MEMORY: begin
                w_next_state     = WRITE_BACK;
                w_ctrl[MEM_R]    = w_mem_rd;
                w_ctrl[MEM_W]    = w_mem_wr;
                w_ctrl[MD_SEL_1] = 1'b0;
            end
            WRITE_BACK: begin
                w_next_state    = FETCH;
                w_ctrl[PC_LOAD] = 1'b1;
                case (w_pc_kind)
                    PC_NEXT: w_ctrl[PC_SEL_1] = 1'b1;
                    PC_BEQ: begin
                        w_ctrl[PC_SEL_2] = bus.i_zero;
                        w_ctrl[PC_SEL_1] = ~bus.i_zero;
                    end
                    PC_BNE: begin
                        w_ctrl[PC_SEL_2] = ~bus.i_zero;
                        w_ctrl[PC_SEL_1] = bus.i_zero;
                    end
                    PC_JUMP: begin
                        w_ctrl[PC_SEL_2] = 1'b1;
                        w_ctrl[PC_SEL_3] = 1'b1;
                    end
                endcase
                case (w_dest)
                    DEST_NONE: ;
                    DEST_RD:   w_ctrl[REG_W] = 1'b1;
                    DEST_RT: begin
                        w_ctrl[REG_W]    = 1'b1;
                        w_ctrl[WA_SEL_1] = 1'b1;
                    end
                    DEST_R31: begin
                        w_ctrl[REG_W]    = 1'b1;
                        w_ctrl[WA_SEL_3] = 1'b1;
                    end
                endcase
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = FETCH;
        endcase
    end

    // Reset forces the control word to zero immediately, aborting any in-flight pulse.
    assign bus.o_ctrl  = i_rst ? 32'h0000_0000 : w_ctrl;
    assign bus.o_state = r_state;
endmodule

// File: tb/tb_control_unit.sv
// Randomised bench for control_unit against a table-driven ISA model plus directed literal checks.
// Build with ILLEGAL_OPCODE_HALT_EN defined to exercise the halting variant.
module tb_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   mPhase = 0;

`ifdef ILLEGAL_OPCODE_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam logic [31:0] INS_ADD  = 32'h0022_1820;
    localparam logic [31:0] INS_SW   = 32'hAC22_0004;
    localparam logic [31:0] INS_BEQ  = 32'h1022_0003;
    localparam logic [31:0] INS_JAL  = 32'h0C00_0010;
    localparam logic [31:0] INS_ILL  = 32'hFC00_0000;

    // dest: 0 none, 1 rd, 2 rt, 3 r31; mem: 0 none, 1 read, 2 write; pc: 0 next, 1 beq, 2 bne, 3 jump
    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] alu;
        bit         rtype;
        int         dest;
        int         mem;
        int         pc;
    } insnDesc_t;

    insnDesc_t isa[$];

    control_unit_if cuIf();

    control_unit dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (cuIf)
    );

    always #5 clk = ~clk;

    task automatic addInsn(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] alu,
                           input bit rt, input int dest, input int mem, input int pc);
        insnDesc_t d;
        d.op = op; d.fn = fn; d.alu = alu; d.rtype = rt;
        d.dest = dest; d.mem = mem; d.pc = pc;
        isa.push_back(d);
    endtask

    function automatic int findInsn(input logic [31:0] ins);
        for (int k = 0; k < isa.size(); k++)
            if (isa[k].op == ins[31:26] && (!isa[k].rtype || isa[k].fn == ins[5:0]))
                return k;
        return -1;
    endfunction

    function automatic bit opKnown(input logic [5:0] op);
        for (int k = 0; k < isa.size(); k++)
            if (isa[k].op == op) return 1'b1;
        return 1'b0;
    endfunction

    // Expected control word for a given phase (0..4 = FETCH..WRITE_BACK, 5 = halted).
    function automatic logic [31:0] modelCtrl(input int phase, input logic [31:0] ins, input logic z);
        logic [31:0] c;
        int          k;
        bit          taken;
        c = 32'h0;
        k = findInsn(ins);
        case (phase)
            0: begin c[5] = 1'b1; c[27] = 1'b1; end
            1: begin c[4] = 1'b1; c[5] = 1'b1; c[8] = 1'b1; c[27] = 1'b1; end
            2: begin
                c[8] = 1'b1;
                if (k >= 0) begin
                    c[25:22] = isa[k].alu;
                    c[21]    = isa[k].rtype;
                end
            end
            3: if (k >= 0) begin
                c[5] = (isa[k].mem == 1);
                c[6] = (isa[k].mem == 2);
            end
            4: begin
                c[0] = 1'b1;
                if (k >= 0 && isa[k].pc == 3) begin
                    c[2] = 1'b1;
                    c[3] = 1'b1;
                end else begin
                    taken = (k >= 0) && ((isa[k].pc == 1 && z) || (isa[k].pc == 2 && !z));
                    c[2]  = taken;
                    c[1]  = !taken;
                end
                if (k >= 0 && isa[k].dest != 0) c[9] = 1'b1;
                if (k >= 0 && isa[k].dest == 2) c[10] = 1'b1;
                if (k >= 0 && isa[k].dest == 3) c[12] = 1'b1;
            end
            default: c = 32'h0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] randomInsn();
        logic [31:0] ins;
        logic [5:0]  op;
        int          k;
        ins = $urandom;
        if ($urandom_range(0, 9) == 0) begin
            do op = 6'($urandom); while (opKnown(op));
            ins[31:26] = op;
        end else begin
            k = $urandom_range(0, isa.size() - 1);
            ins[31:26] = isa[k].op;
            if (isa[k].rtype) ins[5:0] = isa[k].fn;
        end
        return ins;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic z);
        cuIf.i_instruction = ins;
        cuIf.i_zero        = z;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic runInsn(input string name, input logic [31:0] ins, input logic [4:0] z,
                           input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3, input logic [31:0] e4);
        logic [31:0] expCtrl [5];
        expCtrl[0] = e0; expCtrl[1] = e1; expCtrl[2] = e2; expCtrl[3] = e3; expCtrl[4] = e4;
        applyStimulus(ins, z[0]);
        for (int p = 0; p < 5; p++) begin
            cuIf.i_zero = z[p];
            #1;
            checkOutput($sformatf("%s.ctrl%0d", name, p), cuIf.o_ctrl, expCtrl[p]);
            checkOutput($sformatf("%s.state%0d", name, p), {29'b0, cuIf.o_state}, 32'(p + 1));
            stepClock();
        end
    endtask

    // Phase tracker: counts cycles since reset, halts on an unknown instruction in DECODE.
    always @(posedge clk or posedge rst) begin
        if (rst)                                                  mPhase <= 0;
        else if (mPhase == 5)                                     mPhase <= 5;
        else if (mPhase == 1 && HALT_EN && findInsn(cuIf.i_instruction) < 0) mPhase <= 5;
        else                                                      mPhase <= (mPhase + 1) % 5;
    end

    always @(negedge clk) begin
        checkOutput("trackState", {29'b0, cuIf.o_state}, rst ? 32'd1 : 32'(mPhase + 1));
        checkOutput("trackCtrl", cuIf.o_ctrl,
                    rst ? 32'h0 : modelCtrl(mPhase, cuIf.i_instruction, cuIf.i_zero));
    end

    initial begin
        addInsn(6'h00, 6'h20, 4'd1, 1'b1, 1, 0, 0);
        addInsn(6'h00, 6'h22, 4'd2, 1'b1, 1, 0, 0);
        addInsn(6'h00, 6'h2C, 4'd3, 1'b1, 1, 0, 0);
        addInsn(6'h00, 6'h02, 4'd4, 1'b1, 1, 0, 0);
        addInsn(6'h00, 6'h01, 4'd5, 1'b1, 1, 0, 0);
        addInsn(6'h00, 6'h24, 4'd6, 1'b1, 1, 0, 0);
        addInsn(6'h00, 6'h25, 4'd7, 1'b1, 1, 0, 0);
        addInsn(6'h00, 6'h27, 4'd8, 1'b1, 1, 0, 0);
        addInsn(6'h00, 6'h2A, 4'd9, 1'b1, 1, 0, 0);
        addInsn(6'h08, 6'h00, 4'd1, 1'b0, 2, 0, 0);
        addInsn(6'h1D, 6'h00, 4'd3, 1'b0, 2, 0, 0);
        addInsn(6'h0C, 6'h00, 4'd6, 1'b0, 2, 0, 0);
        addInsn(6'h0D, 6'h00, 4'd7, 1'b0, 2, 0, 0);
        addInsn(6'h0A, 6'h00, 4'd9, 1'b0, 2, 0, 0);
        addInsn(6'h23, 6'h00, 4'd1, 1'b0, 2, 1, 0);
        addInsn(6'h2B, 6'h00, 4'd1, 1'b0, 0, 2, 0);
        addInsn(6'h04, 6'h00, 4'd2, 1'b0, 0, 0, 1);
        addInsn(6'h05, 6'h00, 4'd2, 1'b0, 0, 0, 2);
        addInsn(6'h02, 6'h00, 4'd0, 1'b0, 0, 0, 3);
        addInsn(6'h03, 6'h00, 4'd0, 1'b0, 3, 0, 3);
        applyStimulus(INS_ADD, 1'b0);

        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rstState", {29'b0, cuIf.o_state}, 32'd1);
            checkOutput("rstCtrl", cuIf.o_ctrl, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        runInsn("add",  INS_ADD, 5'b00000, 32'h0800_0020, 32'h0800_0130, 32'h0060_0100, 32'h0, 32'h0000_0203);
        runInsn("sw",   INS_SW,  5'b00000, 32'h0800_0020, 32'h0800_0130, 32'h0040_0100, 32'h0000_0040, 32'h0000_0003);
        runInsn("beqA", INS_BEQ, 5'b00100, 32'h0800_0020, 32'h0800_0130, 32'h0080_0100, 32'h0, 32'h0000_0003);
        runInsn("beqB", INS_BEQ, 5'b10000, 32'h0800_0020, 32'h0800_0130, 32'h0080_0100, 32'h0, 32'h0000_0005);
        runInsn("jal",  INS_JAL, 5'b01010, 32'h0800_0020, 32'h0800_0130, 32'h0000_0100, 32'h0, 32'h0000_120D);

        applyStimulus(INS_SW, 1'b0);
        repeat (3) stepClock();
        #1 checkOutput("abortPreMem", cuIf.o_ctrl, 32'h0000_0040);
        rst = 1'b1;
        #1;
        checkOutput("abortCtrl", cuIf.o_ctrl, 32'h0);
        checkOutput("abortState", {29'b0, cuIf.o_state}, 32'd1);
        stepClock();
        rst = 1'b0;
        applyStimulus(INS_ADD, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1 checkOutput("abortNoMemW", {31'b0, cuIf.o_ctrl[6]}, 32'h0);
            stepClock();
        end

`ifdef ILLEGAL_OPCODE_HALT_EN
        applyStimulus(INS_ILL, 1'b0);
        #1 checkOutput("illFetch", cuIf.o_ctrl, 32'h0800_0020);
        stepClock();
        #1 checkOutput("illDecode", cuIf.o_ctrl, 32'h0800_0130);
        stepClock();
        for (int i = 0; i < 10; i++) begin
            cuIf.i_zero = i[0];
            #1;
            checkOutput("haltState", {29'b0, cuIf.o_state}, 32'd6);
            checkOutput("haltCtrl", cuIf.o_ctrl, 32'h0);
            stepClock();
        end
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
`else
        runInsn("illNop", INS_ILL, 5'b00000, 32'h0800_0020, 32'h0800_0130, 32'h0000_0100, 32'h0, 32'h0000_0003);
`endif

        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (mPhase == 0) cuIf.i_instruction = randomInsn();
            cuIf.i_zero = 1'($urandom_range(0, 1));
            if (rst)                                          rst = 1'b0;
            else if (mPhase == 5 && $urandom_range(0, 3) == 0) rst = 1'b1;
            else if ($urandom_range(0, 79) == 0) begin
                #2;
                rst = 1'b1;
            end
            stepClock();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
